// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO data-port router: FSM state encoding and the
// default tag map / readability mask of the standard slave set.
package mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mmio_state_e;

  localparam logic [3:0] TAG_DDR   = 4'h0;
  localparam logic [3:0] TAG_TIMER = 4'hd;
  localparam logic [3:0] TAG_VMEM  = 4'hc;
  localparam logic [3:0] TAG_KBD   = 4'he;

  // Slave order: 0=DDR (default), 1=timer, 2=VMEM (write-only), 3=keyboard
  localparam logic [15:0] SLAVE_TAGS_DEF = {TAG_KBD, TAG_VMEM, TAG_TIMER, TAG_DDR};
  localparam logic [3:0]  RD_MASK_DEF    = 4'b1011;

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational address-tag decoder: picks the lowest-numbered matching slave,
// falling back to slave 0, and reports whether that slave can be read.
module mmio_addr_decode
  import mmio_pkg::*;
#(
  parameter int                              NUM_SLAVES = 4,
  parameter int                              TAG_BITS   = 4,
  parameter int                              IDX_W      = 2,
  parameter logic [NUM_SLAVES*TAG_BITS-1:0]  SLAVE_TAGS = SLAVE_TAGS_DEF,
  parameter logic [NUM_SLAVES-1:0]           RD_MASK    = RD_MASK_DEF
) (
  input  logic [TAG_BITS-1:0]   tag,
  output logic [NUM_SLAVES-1:0] sel,
  output logic [IDX_W-1:0]      idx,
  output logic                  readable
);

  logic [IDX_W-1:0] idx_s;

  // Priority search from the top down so the lowest matching index is kept last
  always_comb begin
    idx_s = {IDX_W{1'b0}};
    for (int i = NUM_SLAVES - 1; i >= 1; i--) begin
      if (tag == SLAVE_TAGS[i*TAG_BITS +: TAG_BITS]) begin
        idx_s = IDX_W'(i);
      end else begin
        idx_s = idx_s;
      end
    end
  end

  assign idx      = idx_s;
  assign sel      = {{(NUM_SLAVES-1){1'b0}}, 1'b1} << idx_s;
  assign readable = RD_MASK[idx_s];

endmodule

// File: rtl/mmio_bus_router.sv
// Single-master, N-slave MMIO router: registers a one-hot request towards the
// decoded slave, waits for its ready (or a timeout) and returns read data.
module mmio_bus_router
  import mmio_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TAG_HI     = 31,
  parameter int TAG_LO     = 28,
  parameter logic [NUM_SLAVES*(TAG_HI-TAG_LO+1)-1:0] SLAVE_TAGS = SLAVE_TAGS_DEF,
  parameter logic [NUM_SLAVES-1:0] RD_MASK = RD_MASK_DEF,
  parameter int TIMEOUT    = 255,
  parameter int TO_W       = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_read,
  input  logic                         cpu_write,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  input  logic [DATA_W/8-1:0]          cpu_byte_en,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_stall,
  output logic                         cpu_err,
  output logic [NUM_SLAVES-1:0]        s_en,
  output logic                         s_write,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [DATA_W/8-1:0]          s_byte_en,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata
);

  localparam int TAG_BITS = TAG_HI - TAG_LO + 1;
  localparam int IDX_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  mmio_state_e             state_r, state_next_s;
  logic [IDX_W-1:0]        sel_idx_r;
  logic [TO_W-1:0]         cnt_r;
  logic [NUM_SLAVES-1:0]   dec_sel_s;
  logic [IDX_W-1:0]        dec_idx_s;
  logic                    dec_readable_s;
  logic                    req_s;
  logic                    ready_sel_s;
  logic                    timeout_s;
  logic [DATA_W-1:0]       rdata_sel_s;

  mmio_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .TAG_BITS   (TAG_BITS),
    .IDX_W      (IDX_W),
    .SLAVE_TAGS (SLAVE_TAGS),
    .RD_MASK    (RD_MASK)
  ) u_decode (
    .tag      (cpu_addr[TAG_HI:TAG_LO]),
    .sel      (dec_sel_s),
    .idx      (dec_idx_s),
    .readable (dec_readable_s)
  );

  assign req_s     = cpu_read | cpu_write;
  assign timeout_s = (cnt_r == TO_W'(TIMEOUT));
  assign cpu_stall = req_s & (state_r != ST_DONE);

  // Route the latched slave's ready and read data; other slaves are ignored
  always_comb begin
    ready_sel_s = 1'b0;
    rdata_sel_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_idx_r == IDX_W'(i)) begin
        ready_sel_s = s_ready[i];
        rdata_sel_s = s_rdata[i*DATA_W +: DATA_W];
      end else begin
        ready_sel_s = ready_sel_s;
        rdata_sel_s = rdata_sel_s;
      end
    end
  end

  // Next-state logic; a read of a write-only slave skips straight to DONE
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          if (cpu_write | dec_readable_s) begin
            state_next_s = ST_WAIT;
          end else begin
            state_next_s = ST_DONE;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (ready_sel_s | timeout_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request latch, timeout counter and completion registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s_en      <= {NUM_SLAVES{1'b0}};
      s_write   <= 1'b0;
      s_addr    <= {ADDR_W{1'b0}};
      s_wdata   <= {DATA_W{1'b0}};
      s_byte_en <= {(DATA_W/8){1'b0}};
      sel_idx_r <= {IDX_W{1'b0}};
      cnt_r     <= {TO_W{1'b0}};
      cpu_rdata <= {DATA_W{1'b0}};
      cpu_err   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cpu_err <= 1'b0;
          if (req_s && (cpu_write || dec_readable_s)) begin
            s_en      <= dec_sel_s;
            s_write   <= cpu_write;
            s_addr    <= cpu_addr;
            s_wdata   <= cpu_wdata;
            s_byte_en <= cpu_byte_en;
            sel_idx_r <= dec_idx_s;
            cnt_r     <= {TO_W{1'b0}};
          end else if (req_s) begin
            cpu_rdata <= {DATA_W{1'b0}};
          end
        end
        ST_WAIT: begin
          // Ready beats a coincident timeout
          if (ready_sel_s) begin
            s_en      <= {NUM_SLAVES{1'b0}};
            cpu_rdata <= s_write ? {DATA_W{1'b0}} : rdata_sel_s;
          end else if (timeout_s) begin
            s_en      <= {NUM_SLAVES{1'b0}};
            cpu_rdata <= {DATA_W{1'b0}};
            cpu_err   <= 1'b1;
          end else begin
            cnt_r <= cnt_r + TO_W'(1);
          end
        end
        ST_DONE: begin
          cpu_err <= 1'b0;
        end
        default: begin
          s_en    <= {NUM_SLAVES{1'b0}};
          cpu_err <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_router.sv
// Randomized bench for mmio_bus_router: each transaction's stall length, strobe,
// read data and error are predicted from the tag map and ready delay.
module tb_mmio_bus_router;

  localparam int TO = 12;
  localparam int NEVER = 1000;

  logic         clk;
  logic         rst;
  logic         cpu_read;
  logic         cpu_write;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [3:0]   cpu_byte_en;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic         cpu_err;
  logic [3:0]   s_en;
  logic         s_write;
  logic [31:0]  s_addr;
  logic [31:0]  s_wdata;
  logic [3:0]   s_byte_en;
  logic [3:0]   s_ready;
  logic [127:0] s_rdata;

  int n_pass;
  int n_checks;

  mmio_bus_router #(.TIMEOUT(TO), .TO_W(4)) dut (
    .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_byte_en(cpu_byte_en),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .s_en(s_en), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_byte_en(s_byte_en), .s_ready(s_ready), .s_rdata(s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Tag map: D=timer(1), C=VMEM(2, write-only), E=keyboard(3), else DDR(0)
  function automatic int ref_slave(input logic [31:0] a);
    case (a[31:28])
      4'hd:    return 1;
      4'hc:    return 2;
      4'he:    return 3;
      default: return 0;
    endcase
  endfunction

  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic rd_too,
                         input logic [31:0] wdata, input logic [3:0] be, input int delay,
                         input logic noise, input logic [31:0] sel_data);
    int          idx;
    logic        issued;
    int          exp_wait;
    int          exp_stall;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  sel_oh;
    int          k;
    int          wait_seen;
    idx       = ref_slave(addr);
    issued    = wr || (idx != 2);
    exp_wait  = !issued ? 0 : ((delay <= TO) ? delay + 1 : TO + 1);
    exp_stall = !issued ? 1 : exp_wait + 1;
    exp_err   = issued && (delay > TO);
    sel_oh    = 4'b0001 << idx;
    for (int i = 0; i < 4; i++) s_rdata[i*32 +: 32] = $urandom;
    s_rdata[idx*32 +: 32] = sel_data;
    exp_rdata = (issued && !wr && delay <= TO) ? sel_data : 32'h0;
    cpu_addr    = addr;
    cpu_wdata   = wdata;
    cpu_byte_en = be;
    cpu_write   = wr;
    cpu_read    = wr ? rd_too : 1'b1;
    k = 0;
    wait_seen = 0;
    #1;
    while (cpu_stall === 1'b1 && k < TO + 10) begin
      if (s_en !== 4'b0000) begin
        if (wait_seen == 0) begin
          check_eq("s_en", {60'h0, s_en}, {60'h0, sel_oh});
          check_eq("s_write", {63'h0, s_write}, {63'h0, wr});
          check_eq("s_addr", {32'h0, s_addr}, {32'h0, addr});
          if (wr) begin
            check_eq("s_wdata", {32'h0, s_wdata}, {32'h0, wdata});
            check_eq("s_byte_en", {60'h0, s_byte_en}, {60'h0, be});
          end
        end
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
        if (wait_seen == delay) s_ready = sel_oh;
        else s_ready = noise ? (4'($urandom) & ~sel_oh) : 4'b0000;
        wait_seen++;
      end else begin
        s_ready = noise ? 4'($urandom) : 4'b0000;
      end
      @(negedge clk);
      #1;
      k++;
    end
    check_eq("stall_cycles", 64'(k), 64'(exp_stall));
    check_eq("s_en_cycles", 64'(wait_seen), 64'(exp_wait));
    check_eq("cpu_rdata", {32'h0, cpu_rdata}, {32'h0, exp_rdata});
    check_eq("cpu_err", {63'h0, cpu_err}, {63'h0, exp_err});
    check_eq("s_en_done", {60'h0, s_en}, 64'h0);
    if (issued) check_eq("s_addr_held", {32'h0, s_addr}, {32'h0, addr});
    s_ready   = noise ? 4'($urandom) : 4'b0000;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    @(negedge clk);
    #1;
    check_eq("err_pulse_end", {63'h0, cpu_err}, 64'h0);
    s_ready = 4'b0000;
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    int          dly;
    logic [3:0]  tags [5];
    n_pass = 0;
    n_checks = 0;
    tags[0] = 4'h0; tags[1] = 4'hc; tags[2] = 4'hd; tags[3] = 4'he; tags[4] = 4'h5;
    rst = 1'b1;
    cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_byte_en = 4'h0;
    s_ready = 4'b0000; s_rdata = 128'h0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_s_en", {60'h0, s_en}, 64'h0);
    check_eq("rst_s_write", {63'h0, s_write}, 64'h0);
    check_eq("rst_s_addr", {32'h0, s_addr}, 64'h0);
    check_eq("rst_s_wdata", {32'h0, s_wdata}, 64'h0);
    check_eq("rst_s_byte_en", {60'h0, s_byte_en}, 64'h0);
    check_eq("rst_rdata", {32'h0, cpu_rdata}, 64'h0);
    check_eq("rst_err", {63'h0, cpu_err}, 64'h0);
    check_eq("rst_stall", {63'h0, cpu_stall}, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    #1;

    run_txn(32'h0000_1000, 1'b0, 1'b0, 32'h0, 4'hf, 3, 1'b0, 32'hDEAD_BEEF);
    run_txn(32'hC000_0004, 1'b1, 1'b0, 32'h0000_4100, 4'b0100, 1, 1'b0, 32'h1234_5678);
    run_txn(32'hC000_0000, 1'b0, 1'b0, 32'h0, 4'hf, 0, 1'b0, 32'h5555_AAAA);
    run_txn(32'hD000_0000, 1'b0, 1'b0, 32'h0, 4'hf, NEVER, 1'b0, 32'h7777_7777);
    run_txn(32'hE000_0000, 1'b0, 1'b0, 32'h0, 4'hf, 2, 1'b1, 32'hCAFE_F00D);
    run_txn(32'h0000_0040, 1'b0, 1'b0, 32'h0, 4'hf, TO, 1'b1, 32'h0BAD_CAFE);
    run_txn(32'hE000_0008, 1'b1, 1'b1, 32'h0000_00AB, 4'b0001, 0, 1'b0, 32'h9999_0000);

    for (int t = 0; t < 80; t++) begin
      a = $urandom;
      a[31:28] = tags[$urandom_range(0, 4)];
      r = $urandom_range(0, 9);
      if (r < 6) dly = r;
      else if (r == 6) dly = TO;
      else if (r == 7) dly = NEVER;
      else dly = $urandom_range(0, TO);
      run_txn(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
              4'($urandom), dly, 1'($urandom_range(0, 1)), $urandom);
    end

    // Reset in the middle of a WAIT, then a late ready from the abandoned slave
    cpu_addr = 32'h0000_0010; cpu_read = 1'b1; cpu_write = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("pre_rst_s_en", {60'h0, s_en}, 64'h1);
    rst = 1'b1; cpu_read = 1'b0;
    @(negedge clk);
    #1;
    check_eq("mid_rst_s_en", {60'h0, s_en}, 64'h0);
    check_eq("mid_rst_stall", {63'h0, cpu_stall}, 64'h0);
    check_eq("mid_rst_rdata", {32'h0, cpu_rdata}, 64'h0);
    rst = 1'b0;
    s_ready = 4'b0001;
    s_rdata[31:0] = 32'hFEED_FACE;
    repeat (2) @(negedge clk);
    #1;
    check_eq("late_rdy_s_en", {60'h0, s_en}, 64'h0);
    check_eq("late_rdy_rdata", {32'h0, cpu_rdata}, 64'h0);
    check_eq("late_rdy_err", {63'h0, cpu_err}, 64'h0);
    check_eq("late_rdy_stall", {63'h0, cpu_stall}, 64'h0);
    s_ready = 4'b0000;
    run_txn(32'hD000_0100, 1'b0, 1'b0, 32'h0, 4'hf, 1, 1'b0, 32'h0101_0202);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
